// File: rtl/cpu_types_pkg.sv
// Shared types for the request sequencer.
// Holds the state encoding of the memory-request FSM so that the design and
// any debug tooling agree on the numeric value of each state.
package cpu_types_pkg;

  // IDLE   : one-cycle pause after reset before the first fetch
  // FETCH  : instruction request outstanding, waiting for ihit
  // DATA   : load/store request outstanding, waiting for dhit
  // HALTED : terminal state, left only through reset
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DATA   = 2'd2,
    HALTED = 2'd3
  } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// Handshake bundle between the control unit / memory arbiter and the
// request unit.
//   iREN, dREN, dWEN, halt : decoded strobes from the control unit
//   ihit, dhit             : hit indications from the memory arbiter
//   imemREN, dmemREN,
//   dmemWEN                : held memory requests toward the arbiter
//   pcEN                   : one-cycle commit strobe toward the datapath
// The master modport is the request unit itself; the slave modport is the
// surrounding environment (control unit plus arbiter).
interface request_unit_if;

  logic iREN;
  logic dREN;
  logic dWEN;
  logic halt;
  logic ihit;
  logic dhit;
  logic imemREN;
  logic dmemREN;
  logic dmemWEN;
  logic pcEN;

  modport master (
    input  iREN, dREN, dWEN, halt, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, pcEN
  );

  modport slave (
    output iREN, dREN, dWEN, halt, ihit, dhit,
    input  imemREN, dmemREN, dmemWEN, pcEN
  );

endinterface

// File: rtl/request_unit_sat_counter.sv
// Saturating up-counter used for the per-access watchdog and the stall
// performance counter.
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active-high, clears the count
//   inc_i   : add one this cycle (ignored once the count is all-ones)
//   clr_i   : synchronous clear, takes priority over inc_i
//   count_o : current count
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear beats increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer sitting after the control unit. Converts the
// decoded fetch/load/store/halt strobes into held requests toward the memory
// arbiter, waits for the matching hit and emits one pcEN per instruction.
// Also keeps a sticky halt, a per-access watchdog and a stall counter.
//   CLK       : clock, rising edge
//   RST       : asynchronous reset, active-high
//   bus       : request_unit_if master (strobes, hits, requests, pcEN)
//   halt_o    : sticky halted flag
//   timeout_o : sticky flag, watchdog expired on an access
//   err_o     : sticky flag, dREN and dWEN were seen together
//   stall_cnt : FETCH/DATA cycles without pcEN, saturating
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int STALL_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  request_unit_if.master     bus,
  output logic               halt_o,
  output logic               timeout_o,
  output logic               err_o,
  output logic [STALL_W-1:0] stall_cnt
);

  // Wide enough to hold TIMEOUT itself, so the last-cycle compare never wraps.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  reqstate_t   state_q;
  reqstate_t   state_d;
  logic        wr_q;
  logic        wr_d;
  logic        halt_q;
  logic        halt_d;
  logic        timeout_q;
  logic        timeout_d;
  logic        err_q;
  logic        err_d;

  logic              busy;
  logic              fetchHit;
  logic              dataHit;
  logic              anyHit;
  logic              dataReq;
  logic              latchData;
  logic              waitExpired;
  logic              pcEn;
  logic              waitClr;
  logic              waitInc;
  logic              stallInc;
  logic [WAIT_W-1:0] waitCnt;

  // Only the hit matching the current state counts; stray hits are dropped.
  assign busy     = (state_q == FETCH) || (state_q == DATA);
  assign fetchHit = (state_q == FETCH) && bus.ihit;
  assign dataHit  = (state_q == DATA) && bus.dhit;
  assign anyHit   = fetchHit || dataHit;
  assign dataReq  = bus.dREN || bus.dWEN;

  // A fetched halt overrides any memory op decoded on the same instruction.
  assign latchData = fetchHit && !bus.halt && dataReq;

  // A hit on the watchdog's last cycle still completes the access.
  assign waitExpired = busy && !anyHit && (waitCnt == WAIT_LAST);

  assign pcEn = (fetchHit && !bus.halt && !dataReq) || dataHit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (fetchHit) begin
          if (bus.halt)    state_d = HALTED;
          else if (dataReq) state_d = DATA;
          else              state_d = FETCH;
        end else if (waitExpired) begin
          state_d = HALTED;
        end
      end
      DATA: begin
        if (dataHit)          state_d = FETCH;
        else if (waitExpired) state_d = HALTED;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Load-vs-store kind is captured at ihit and held for the whole DATA phase;
  // a simultaneous read and write is resolved as a write and flagged.
  always_comb begin
    wr_d      = wr_q;
    err_d     = err_q;
    halt_d    = halt_q || (state_d == HALTED);
    timeout_d = timeout_q || waitExpired;
    if (latchData) begin
      wr_d = bus.dWEN;
      if (bus.dREN && bus.dWEN) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  // The watchdog restarts for every new access: on any state change and on
  // every committed instruction (back-to-back fetches stay in FETCH).
  assign waitClr  = (state_d != state_q) || pcEn;
  assign waitInc  = busy && !anyHit;
  assign stallInc = busy && !pcEn;

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk     (CLK),
    .rst     (RST),
    .inc_i   (waitInc),
    .clr_i   (waitClr),
    .count_o (waitCnt)
  );

  sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
    .clk     (CLK),
    .rst     (RST),
    .inc_i   (stallInc),
    .clr_i   (1'b0),
    .count_o (stall_cnt)
  );

  // Requests are decoded from state; the fetch request also follows iREN.
  assign bus.imemREN = (state_q == FETCH) && bus.iREN;
  assign bus.dmemREN = (state_q == DATA) && !wr_q;
  assign bus.dmemWEN = (state_q == DATA) && wr_q;
  assign bus.pcEN    = pcEn;

  assign halt_o    = halt_q;
  assign timeout_o = timeout_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit. Two instances share the same stimulus:
// dutA is the main instance (TIMEOUT=4, 32-bit stall counter) and dutB uses a
// 2-bit stall counter so that saturation is reached within a short sequence.
module tb_request_unit;

  logic        CLK;
  logic        RST;
  logic        haltA;
  logic        timeoutA;
  logic        errA;
  logic [31:0] stallA;
  logic        haltB;
  logic        timeoutB;
  logic        errB;
  logic [1:0]  stallB;

  int compared;
  int mismatched;

  request_unit_if ifA ();
  request_unit_if ifB ();

  assign ifB.iREN = ifA.iREN;
  assign ifB.dREN = ifA.dREN;
  assign ifB.dWEN = ifA.dWEN;
  assign ifB.halt = ifA.halt;
  assign ifB.ihit = ifA.ihit;
  assign ifB.dhit = ifA.dhit;

  request_unit #(.TIMEOUT(4), .STALL_W(32)) dutA (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (ifA),
    .halt_o    (haltA),
    .timeout_o (timeoutA),
    .err_o     (errA),
    .stall_cnt (stallA)
  );

  request_unit #(.TIMEOUT(4), .STALL_W(2)) dutB (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (ifB),
    .halt_o    (haltB),
    .timeout_o (timeoutB),
    .err_o     (errB),
    .stall_cnt (stallB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive the control-unit strobes and hits, then let combinational outputs settle.
  task automatic applyStimulus(input logic iRen, input logic dRen, input logic dWen,
                               input logic haltIn, input logic iHit, input logic dHit);
    ifA.iREN = iRen;
    ifA.dREN = dRen;
    ifA.dWEN = dWen;
    ifA.halt = haltIn;
    ifA.ihit = iHit;
    ifA.dhit = dHit;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic releaseReset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    RST = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset: requests stay low even with iREN asserted.
    checkOutput("rst_imemREN", 32'(ifA.imemREN), 32'd0);
    checkOutput("rst_dmemREN", 32'(ifA.dmemREN), 32'd0);
    checkOutput("rst_pcEN", 32'(ifA.pcEN), 32'd0);
    checkOutput("rst_halt", 32'(haltA), 32'd0);
    checkOutput("rst_timeout", 32'(timeoutA), 32'd0);
    checkOutput("rst_err", 32'(errA), 32'd0);
    checkOutput("rst_stall", stallA, 32'd0);
    checkOutput("rst_stallB", 32'(stallB), 32'd0);

    // One IDLE cycle after release, then the first fetch.
    releaseReset();
    checkOutput("idle_imemREN", 32'(ifA.imemREN), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("f1_imemREN", 32'(ifA.imemREN), 32'd1);
    checkOutput("f1_stall", stallA, 32'd0);
    tick();
    checkOutput("f2_stall", stallA, 32'd1);

    // ALU op: ihit after two wait cycles.
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("alu_pcEN", 32'(ifA.pcEN), 32'd1);
    checkOutput("alu_stall", stallA, 32'd2);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("alu_pcEN_off", 32'(ifA.pcEN), 32'd0);
    checkOutput("alu_still_fetch", 32'(ifA.imemREN), 32'd1);
    checkOutput("alu_stall_hold", stallA, 32'd2);

    // Load: ihit with dREN in this same cycle.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ld_fetch_pcEN", 32'(ifA.pcEN), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ld_imemREN", 32'(ifA.imemREN), 32'd0);
    checkOutput("ld_dmemREN", 32'(ifA.dmemREN), 32'd1);
    checkOutput("ld_dmemWEN", 32'(ifA.dmemWEN), 32'd0);
    checkOutput("ld_stall1", stallA, 32'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ld_ihit_ignored", 32'(ifA.pcEN), 32'd0);
    checkOutput("ld_dmemREN_held", 32'(ifA.dmemREN), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ld_pcEN", 32'(ifA.pcEN), 32'd1);
    checkOutput("ld_dmemREN_last", 32'(ifA.dmemREN), 32'd1);
    checkOutput("ld_stall", stallA, 32'd5);
    checkOutput("sat_stallB", 32'(stallB), 32'd3);

    // Back in FETCH; a stray dhit must not commit.
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("dhit_ignored", 32'(ifA.pcEN), 32'd0);
    checkOutput("post_ld_dmemREN", 32'(ifA.dmemREN), 32'd0);
    checkOutput("post_ld_imemREN", 32'(ifA.imemREN), 32'd1);

    // Watchdog boundary: ihit on the fourth waiting cycle wins.
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bnd_pcEN", 32'(ifA.pcEN), 32'd1);
    checkOutput("bnd_stall", stallA, 32'd8);
    tick();
    checkOutput("bnd_timeout", 32'(timeoutA), 32'd0);
    checkOutput("bnd_halt", 32'(haltA), 32'd0);

    // dREN and dWEN together: handled as a store, error flagged.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("err_fetch_pcEN", 32'(ifA.pcEN), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("err_dmemWEN", 32'(ifA.dmemWEN), 32'd1);
    checkOutput("err_dmemREN", 32'(ifA.dmemREN), 32'd0);
    checkOutput("err_flag", 32'(errA), 32'd1);
    checkOutput("err_pcEN", 32'(ifA.pcEN), 32'd1);

    // Halt with a store on the same instruction: halt wins.
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("hlt_fetch_pcEN", 32'(ifA.pcEN), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("hlt_imemREN", 32'(ifA.imemREN), 32'd0);
    checkOutput("hlt_dmemWEN", 32'(ifA.dmemWEN), 32'd0);
    checkOutput("hlt_pcEN", 32'(ifA.pcEN), 32'd0);
    checkOutput("hlt_flag", 32'(haltA), 32'd1);
    checkOutput("hlt_stall", stallA, 32'd10);
    tick();
    tick();
    tick();
    checkOutput("hlt_stall_frozen", stallA, 32'd10);
    checkOutput("hlt_flag_sticky", 32'(haltA), 32'd1);
    checkOutput("hlt_imemREN_late", 32'(ifA.imemREN), 32'd0);

    // Reset clears the sticky flags and the counter immediately.
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst2_halt", 32'(haltA), 32'd0);
    checkOutput("rst2_err", 32'(errA), 32'd0);
    checkOutput("rst2_stall", stallA, 32'd0);
    tick();
    releaseReset();
    tick();

    // Timeout: ihit never arrives.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("to_f1_imemREN", 32'(ifA.imemREN), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("to_f4_timeout", 32'(timeoutA), 32'd0);
    checkOutput("to_f4_imemREN", 32'(ifA.imemREN), 32'd1);
    tick();
    checkOutput("to_timeout", 32'(timeoutA), 32'd1);
    checkOutput("to_halt", 32'(haltA), 32'd1);
    checkOutput("to_imemREN", 32'(ifA.imemREN), 32'd0);

    // Reset in the middle of a store drops the request without waiting for a clock.
    RST = 1'b1;
    tick();
    releaseReset();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("async_pre_dmemWEN", 32'(ifA.dmemWEN), 32'd1);
    #1;
    RST = 1'b1;
    #1;
    checkOutput("async_dmemWEN", 32'(ifA.dmemWEN), 32'd0);
    checkOutput("async_timeout", 32'(timeoutA), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
